// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and constants for the run controller.
//   state_t       : controller states (IDLE, RESET, RUN, DONE)
//   STATUS_*      : encodings of the 2-bit status output
//   PC_REPEAT     : number of consecutive RUN cycles at one PC treated as a halt
//                   (only used when RUN_CTRL_PC_WATCH_EN is defined)
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] STATUS_NONE    = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_FAIL    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam int PC_REPEAT = 4;

endpackage

// File: rtl/run_ctrl_watchdog.sv
// run_ctrl_watchdog: up-counter with synchronous clear and enable.
//   clk   in  : clock
//   rst   in  : synchronous active-high reset, zeroes the count
//   clear in  : synchronous clear (takes priority over en)
//   en    in  : count enable
//   count out : number of enabled cycles since the last clear
//   hit   out : high in the enabled cycle that is the LIMIT-th since clear,
//               so the owner can act on the same edge that completes it
module run_ctrl_watchdog #(
  parameter int W     = 32,
  parameter int LIMIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         hit
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign hit = en && (count == LAST);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run controller for single-cycle RISC-V simulations and FPGA
// self-test wrappers. Sequences the core reset, counts run cycles, snoops
// data-memory writes to the tohost mailbox for pass/fail and enforces a
// run-cycle timeout.
//
// Optional feature macro: RUN_CTRL_PC_WATCH_EN adds input core_pc and ends
// a run as PASS when the PC sits still for PC_REPEAT consecutive RUN cycles.
//
// Ports:
//   clk         in  : clock, rising edge
//   rst         in  : synchronous active-high reset
//   start       in  : run request, honoured in IDLE and DONE only
//   mem_we      in  : core data-memory write enable
//   mem_addr    in  : core data-memory address
//   mem_wdata   in  : core data-memory write data
//   core_pc     in  : core program counter (RUN_CTRL_PC_WATCH_EN only)
//   core_rst    out : core reset, asserted level set by CORE_RST_ACTIVE_LOW
//   done        out : high while in DONE
//   status      out : 0 none, 1 pass, 2 fail, 3 timeout
//   result_code out : mem_wdata >> 1 of the failing tohost write, else 0
//   cycle_count out : completed RUN cycles of the current/last run
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after rst; core held in reset, waiting for start
// RESET  | core held in reset for RESET_CYCLES cycles
// RUN    | core running; tohost snoop, PC watch and timeout active
// DONE   | core frozen in reset, results held, start reruns
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                RESET_CYCLES        = 10,
  parameter int                TIMEOUT_CYCLES      = 150,
  parameter int                CNT_W               = 32,
  parameter int                ADDR_W              = 32,
  parameter int                DATA_W              = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR         = 32'h0000_0FF0,
  parameter bit                CORE_RST_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
`ifdef RUN_CTRL_PC_WATCH_EN
  input  logic [ADDR_W-1:0] core_pc,
`endif
  output logic              core_rst,
  output logic              done,
  output logic [1:0]        status,
  output logic [DATA_W-1:0] result_code,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic RST_ON  = CORE_RST_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic RST_OFF = ~RST_ON;
  localparam int   RST_W   = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

  state_t             state;
  logic               start_ok;
  logic               rst_hit;
  logic               cyc_hit;
  logic               tohost_hit;
  logic               pc_halt;
  logic [RST_W-1:0]   rst_cnt_unused;

  // start only counts in the two resting states; in RESET/RUN it is ignored
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);

  run_ctrl_watchdog #(
    .W     (RST_W),
    .LIMIT (RESET_CYCLES)
  ) u_rst_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (state == ST_RESET),
    .count (rst_cnt_unused),
    .hit   (rst_hit)
  );

  // Counts every RUN cycle including the one that ends the run, so DONE
  // shows hit-cycle index + 1, or exactly TIMEOUT_CYCLES on timeout.
  run_ctrl_watchdog #(
    .W     (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (state == ST_RUN),
    .count (cycle_count),
    .hit   (cyc_hit)
  );

`ifdef RUN_CTRL_PC_WATCH_EN
  logic [ADDR_W-1:0] pc_last;
  logic [2:0]        pc_streak;   // RUN cycles already spent at pc_last

  always_ff @(posedge clk) begin
    if (rst || (state != ST_RUN)) begin
      pc_last   <= '0;
      pc_streak <= '0;
    end else begin
      pc_last <= core_pc;
      if ((pc_streak != 3'd0) && (core_pc == pc_last)) begin
        pc_streak <= pc_streak + 3'd1;
      end else begin
        pc_streak <= 3'd1;
      end
    end
  end

  assign pc_halt = (state == ST_RUN) && (pc_streak != 3'd0) &&
                   (core_pc == pc_last) && (pc_streak == 3'(PC_REPEAT - 1));
`else
  assign pc_halt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      core_rst    <= RST_ON;
      done        <= 1'b0;
      status      <= STATUS_NONE;
      result_code <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          core_rst <= RST_ON;
          if (start) begin
            state       <= ST_RESET;
            status      <= STATUS_NONE;
            result_code <= '0;
          end
        end

        ST_RESET: begin
          if (rst_hit) begin
            state    <= ST_RUN;
            core_rst <= RST_OFF;
          end
        end

        ST_RUN: begin
          // priority: tohost hit, then timeout, then PC halt
          if (tohost_hit) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            core_rst <= RST_ON;
            if (mem_wdata == DATA_W'(1)) begin
              status      <= STATUS_PASS;
              result_code <= '0;
            end else begin
              status      <= STATUS_FAIL;
              result_code <= mem_wdata >> 1;
            end
          end else if (cyc_hit) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            core_rst    <= RST_ON;
            status      <= STATUS_TIMEOUT;
            result_code <= '0;
          end else if (pc_halt) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            core_rst    <= RST_ON;
            status      <= STATUS_PASS;
            result_code <= '0;
          end
        end

        ST_DONE: begin
          if (start) begin
            state       <= ST_RESET;
            done        <= 1'b0;
            status      <= STATUS_NONE;
            result_code <= '0;
          end
        end

        default: begin
          state    <= ST_IDLE;
          core_rst <= RST_ON;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: self-checking bench for run_ctrl (default build).
// Expected results come from scanning the generated per-cycle write stimulus
// for the first tohost write within the run-cycle budget.
module tb_run_ctrl;

  localparam int          RC     = 10;
  localparam int          TO     = 150;
  localparam logic [31:0] TOHOST = 32'h0000_0FF0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic [1:0]  status;
  logic [31:0] result_code;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic        stim_we    [TO];
  logic [31:0] stim_addr  [TO];
  logic [31:0] stim_data  [TO];
  logic        stim_start [TO];

  always #5 clk = ~clk;

  run_ctrl #(
    .RESET_CYCLES        (RC),
    .TIMEOUT_CYCLES      (TO),
    .CNT_W               (32),
    .ADDR_W              (32),
    .DATA_W              (32),
    .TOHOST_ADDR         (TOHOST),
    .CORE_RST_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .done        (done),
    .status      (status),
    .result_code (result_code),
    .cycle_count (cycle_count)
  );

  // Reference: first tohost write at run index i ends the run with count
  // i+1; data 1 is pass, anything else fail with data>>1; none is timeout.
  function automatic void model(output logic [1:0] st, output logic [31:0] rc,
                                output int cnt);
    bit found = 0;
    st  = 2'd3;
    rc  = 32'd0;
    cnt = TO;
    for (int i = 0; i < TO; i++) begin
      if (!found && stim_we[i] && stim_addr[i] == TOHOST) begin
        found = 1;
        cnt   = i + 1;
        if (stim_data[i] == 32'd1) st = 2'd1;
        else begin
          st = 2'd2;
          rc = stim_data[i] >> 1;
        end
      end
    end
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < TO; i++) begin
      stim_we[i]    = 1'b0;
      stim_addr[i]  = 32'd0;
      stim_data[i]  = 32'd0;
      stim_start[i] = 1'b0;
    end
  endtask

  task automatic noise_stim();
    logic [31:0] a;
    for (int i = 0; i < TO; i++) begin
      case ($urandom_range(0, 3))
        0: a = TOHOST + 32'd4;
        1: a = TOHOST - 32'd4;
        2: a = TOHOST ^ (32'd1 << $urandom_range(0, 31));
        default: a = $urandom;
      endcase
      if (a == TOHOST) a = a ^ 32'h8000_0000;
      stim_we[i]    = ($urandom_range(0, 1) == 1);
      stim_addr[i]  = a;
      stim_data[i]  = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
      stim_start[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Starts a run from IDLE or DONE, follows it to DONE and checks results.
  task automatic run_and_check(input string name, input bit pulse_in_reset);
    logic [1:0]  est;
    logic [31:0] erc;
    int          ecnt;
    int          n;
    int          cnt_bad;
    model(est, erc, ecnt);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || status !== 2'd0 || result_code !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL %s cleared_on_start: done=%0d status=%0d result=%0h count=%0d, want all 0",
               name, done, status, result_code, cycle_count);
    end

    n = 1;
    while (core_rst !== 1'b1 && n < 3 * RC) begin
      start = pulse_in_reset && (n == 3);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (n !== RC + 1) begin
      errors++;
      $display("FAIL %s reset_length: core_rst released %0d cycles after start, want %0d",
               name, n, RC + 1);
    end

    n = 0;
    cnt_bad = 0;
    while (done !== 1'b1 && n < TO + 5) begin
      if (cycle_count !== n) cnt_bad++;
      if (n < TO) begin
        mem_we    = stim_we[n];
        mem_addr  = stim_addr[n];
        mem_wdata = stim_data[n];
        start     = stim_start[n];
      end else begin
        mem_we = 1'b0;
        start  = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    mem_we = 1'b0;
    start  = 1'b0;

    checks++;
    if (cnt_bad != 0) begin
      errors++;
      $display("FAIL %s count_track: %0d RUN cycles with cycle_count != index, want 0", name, cnt_bad);
    end
    checks++;
    if (done !== 1'b1 || n !== ecnt) begin
      errors++;
      $display("FAIL %s done_latency: done=%0d after %0d RUN cycles, want done=1 after %0d",
               name, done, n, ecnt);
    end
    checks++;
    if (status !== est) begin
      errors++;
      $display("FAIL %s status: got %0d, want %0d", name, status, est);
    end
    checks++;
    if (result_code !== erc) begin
      errors++;
      $display("FAIL %s result_code: got %0h, want %0h", name, result_code, erc);
    end
    checks++;
    if (cycle_count !== ecnt) begin
      errors++;
      $display("FAIL %s cycle_count: got %0d, want %0d", name, cycle_count, ecnt);
    end
    checks++;
    if (core_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s done_core_rst: got %0d, want 0", name, core_rst);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || status !== est || result_code !== erc || cycle_count !== ecnt || core_rst !== 1'b0) begin
      errors++;
      $display("FAIL %s done_hold: done=%0d status=%0d result=%0h count=%0d core_rst=%0d, want 1/%0d/%0h/%0d/0",
               name, done, status, result_code, cycle_count, core_rst, est, erc, ecnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b0 || status !== 2'd0 || result_code !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: core_rst=%0d done=%0d status=%0d result=%0h count=%0d, want 0s",
               core_rst, done, status, result_code, cycle_count);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: core_rst=%0d done=%0d, want 0/0", core_rst, done);
    end
  endtask

  task automatic test_pass();
    clear_stim();
    stim_we[20] = 1'b1; stim_addr[20] = TOHOST; stim_data[20] = 32'd1;
    run_and_check("pass", 1'b0);
  endtask

  task automatic test_fail();
    clear_stim();
    stim_we[5]  = 1'b1; stim_addr[5]  = 32'h0000_0FF4; stim_data[5]  = 32'd1;
    stim_we[12] = 1'b1; stim_addr[12] = TOHOST;        stim_data[12] = 32'd7;
    run_and_check("fail", 1'b0);
  endtask

  task automatic test_timeout();
    clear_stim();
    run_and_check("timeout", 1'b0);
  endtask

  task automatic test_hit_at_timeout();
    clear_stim();
    stim_we[TO-1] = 1'b1; stim_addr[TO-1] = TOHOST; stim_data[TO-1] = 32'd1;
    run_and_check("hit_at_timeout", 1'b0);
  endtask

  task automatic test_rst_midrun();
    int n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (core_rst !== 1'b1 && n < 3 * RC) begin
      @(negedge clk);
      n++;
    end
    repeat (50) @(negedge clk);
    checks++;
    if (cycle_count !== 32'd50 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_count: count=%0d done=%0d, want 50/0", cycle_count, done);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b0 || status !== 2'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL midrun_abort: core_rst=%0d done=%0d status=%0d count=%0d, want 0s",
               core_rst, done, status, cycle_count);
    end
    rst = 1'b0;
    repeat (RC + 3) @(negedge clk);
    checks++;
    if (core_rst !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_stays_idle: core_rst=%0d done=%0d, want 0/0", core_rst, done);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int k;
      noise_stim();
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, TO - 1);
        stim_we[k]   = 1'b1;
        stim_addr[k] = TOHOST;
        stim_data[k] = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      end
      run_and_check("random", 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    clear_stim();
    stim_we[0] = 1'b1; stim_addr[0] = TOHOST; stim_data[0] = 32'hFFFF_FFFF;
    run_and_check("b2b_first", 1'b0);
    clear_stim();
    stim_we[3] = 1'b1; stim_addr[3] = TOHOST; stim_data[3] = 32'd1;
    run_and_check("b2b_second", 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_hit_at_timeout();
    test_rst_midrun();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish by %0t", $time);
    $fatal(1, "bench timeout");
  end

endmodule
